dma_bus_arbiter: RTL and testbench
==================================

Name: dma_bus_arbiter

Overview:
- Owns the shared system bus: address_bus, data_bus, rd, wr and mem_io.
- Shares the bus between the CPU (default owner) and up to N_REQ DMA-capable peripherals, for example IDE, UART and PIO.
- Runs the CPU hold handshake (dma_req/dma_ack) and grants one requester at a time in round-robin order.
- Forces the bus back to the CPU between bursts so the CPU always makes progress.

Parameters:
- N_REQ, 4, number of DMA requesters (2..8).
- ID_W, $clog2(N_REQ), width of the owner id.
- MAX_BURST, 256, cycles a grant may last before forced release. Only used when the timeout feature is compiled in.

Ports:
- clk  in  1  system clock.
- arst  in  1  reset. Synchronous and active-high, despite the codebase name.
- req  in  N_REQ  per-requester bus request. A requester holds it high for the whole burst.
- gnt  out  N_REQ  per-requester grant. One-hot or zero, registered.
- dma_req  out  1  hold request to the CPU.
- dma_ack  in  1  CPU has tri-stated the bus.
- owner_id  out  ID_W  index of the current or last granted requester.
- dma_active  out  1  high while any gnt bit is high.
- proto_err  out  1  sticky flag: protocol violation seen.

Behaviour:
- Reset values (arst sampled high at a clk edge): state=IDLE, gnt=0, dma_req=0, owner_id=0, dma_active=0, proto_err=0, rr_ptr=N_REQ-1, winner=0. Reset mid-burst drops gnt and dma_req on the next edge.
- All outputs are registered.
- States: IDLE, HOLD_REQ, GRANT, RELEASE.
- IDLE:
  - If |req, latch winner = first set bit scanning from rr_ptr+1 upward with wrap.
  - Set dma_req=1 and go to HOLD_REQ. Latency from req to dma_req is 1 clk.
- HOLD_REQ:
  - dma_ack=1 → gnt[winner]=1, owner_id=winner, rr_ptr=winner, go to GRANT. Latency from dma_ack to gnt is 1 clk.
  - If req[winner] drops before dma_ack: abort. dma_req=0, go to RELEASE, no grant, rr_ptr unchanged.
- GRANT:
  - Stay while req[winner]=1 and dma_ack=1.
  - req[winner]=0 → gnt=0, dma_req=0, go to RELEASE.
  - dma_ack=0 while granted → gnt=0, dma_req=0, proto_err=1, go to RELEASE.
- RELEASE:
  - Hold dma_req=0 until dma_ack=0, then go to IDLE.
  - The CPU therefore always owns the bus for at least one cycle between bursts.
- Simultaneous requests: only the winner is served. Others stay pending and are re-arbitrated in IDLE.
- A new req arriving in HOLD_REQ does not change the latched winner.
- Pointer update: the rr_ptr update gives the just-served requester lowest priority next round.
- Wrap: the scan from rr_ptr=N_REQ-1 starts at bit 0.
- Reserved index: with N_REQ < 2**ID_W, indices ≥ N_REQ are never selected.
- dma_active = |gnt.
- gnt is never high while dma_ack=0, as seen at any clk edge after the first detection.

Optional Feature:
- Macro: DMA_BUS_ARB_TIMEOUT_EN.
- With it:
  - An 8..16-bit burst counter clears on entry to GRANT and increments each GRANT cycle.
  - At count == MAX_BURST-1: gnt=0, dma_req=0, go to RELEASE, even if req is still high.
  - rr_ptr already points at the preempted requester, so other pending requesters win first.
  - A preempted requester re-enters arbitration normally.
- Without it: no counter logic exists, and a burst lasts until req drops.

Decomposition:
- Package dma_bus_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_t {IDLE, HOLD_REQ, GRANT, RELEASE};
  - localparam DEFAULT_N_REQ=4 and DEFAULT_MAX_BURST=256.
- One sub-module, rr_picker:
  - Purely combinational.
  - Inputs: req vector and rr_ptr.
  - Outputs: winner index and a valid flag.
- The FSM, counter and registers live in dma_bus_arbiter.

Test Plan:
- Single request: req=4'b0100, CPU answers dma_ack 2 clks after dma_req → dma_req at +1 clk, gnt=4'b0100 and owner_id=2 one clk after dma_ack. req drops → gnt=0 and dma_req=0 next clk, then IDLE after dma_ack falls.
- Round-robin: req=4'b1111 held, each burst 3 clks → grant order 0,1,2,3,0, with dma_req low between every burst.
- Abort: req=4'b0010 drops while in HOLD_REQ before dma_ack → no gnt ever, dma_req falls, rr_ptr unchanged, so the next req=4'b0011 grants index 0.
- Protocol error: dma_ack forced low during GRANT → gnt=0 next clk, proto_err=1 and stays 1 until arst.
- Reset mid-burst: arst pulsed one clk during GRANT → next edge gives gnt=0, dma_req=0, proto_err=0, state IDLE; with req still high, re-arbitration starts at index 0.
- Timeout (DMA_BUS_ARB_TIMEOUT_EN, MAX_BURST=16): req=4'b0011 held → gnt[0] lasts exactly 16 clks then drops, the next grant goes to index 1, then back to index 0.

Source files
------------

// File: rtl/dma_bus_arbiter_pkg.sv
// Shared types and defaults for the DMA bus arbiter.
package dma_bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD_REQ,
    GRANT,
    RELEASE
  } arb_state_t;

  localparam int DEFAULT_N_REQ     = 4;
  localparam int DEFAULT_MAX_BURST = 256;

endpackage

// File: rtl/dma_bus_arbiter_if.sv
// Handshake bundle between the DMA requesters, the CPU hold logic and the arbiter.
interface dma_bus_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic             dma_req;
  logic             dma_ack;
  logic [ID_W-1:0]  owner_id;
  logic             dma_active;
  logic             proto_err;

  modport master (
    input  req,
    input  dma_ack,
    output gnt,
    output dma_req,
    output owner_id,
    output dma_active,
    output proto_err
  );

  modport slave (
    output req,
    output dma_ack,
    input  gnt,
    input  dma_req,
    input  owner_id,
    input  dma_active,
    input  proto_err
  );
endinterface

// File: rtl/dma_bus_arbiter_rr_picker.sv
// Combinational round-robin pick: first set req bit after rr_ptr, wrapping at N_REQ.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [ID_W-1:0]  winner,
  output logic             valid
);
  always_comb begin
    int unsigned idx;
    winner = '0;
    valid  = 1'b0;
    // Scan from farthest to nearest so the nearest set bit is written last.
    for (int unsigned i = N_REQ; i >= 1; i--) begin
      idx = (int'(rr_ptr) + i) % N_REQ;
      if (req[idx]) begin
        winner = ID_W'(idx);
        valid  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dma_bus_arbiter.sv
// Round-robin DMA bus arbiter with CPU hold handshake.
// Optional burst timeout compiled in with DMA_BUS_ARB_TIMEOUT_EN.
module dma_bus_arbiter
  import dma_bus_arb_pkg::*;
#(
  parameter int N_REQ     = DEFAULT_N_REQ,
  parameter int ID_W      = $clog2(N_REQ),
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input logic               clk,
  input logic               arst,
  dma_bus_arbiter_if.master bus
);

  if (N_REQ < 2 || N_REQ > 8 || MAX_BURST < 2) begin : g_param_check
    $error("dma_bus_arbiter: unsupported N_REQ or MAX_BURST");
  end

  arb_state_t       state, state_nxt;
  logic [N_REQ-1:0] gnt_q, gnt_nxt;
  logic             dma_req_q, dma_req_nxt;
  logic             active_q, active_nxt;
  logic             proto_err_q, proto_err_nxt;
  logic [ID_W-1:0]  owner_q, owner_nxt;
  logic [ID_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [ID_W-1:0]  winner, winner_nxt;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_valid;
  logic             burst_done;

  rr_picker #(.N_REQ(N_REQ), .ID_W(ID_W)) u_picker (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

`ifdef DMA_BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = 16;
  logic [CNT_W-1:0] burst_cnt;

  always_ff @(posedge clk) begin
    if (arst || state != GRANT) burst_cnt <= '0;
    else                        burst_cnt <= burst_cnt + 1'b1;
  end

  assign burst_done = (burst_cnt == CNT_W'(MAX_BURST - 1));
`else
  assign burst_done = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (arst) begin
      state       <= IDLE;
      gnt_q       <= '0;
      dma_req_q   <= 1'b0;
      active_q    <= 1'b0;
      proto_err_q <= 1'b0;
      owner_q     <= '0;
      rr_ptr      <= ID_W'(N_REQ - 1);
      winner      <= '0;
    end else begin
      state       <= state_nxt;
      gnt_q       <= gnt_nxt;
      dma_req_q   <= dma_req_nxt;
      active_q    <= active_nxt;
      proto_err_q <= proto_err_nxt;
      owner_q     <= owner_nxt;
      rr_ptr      <= rr_ptr_nxt;
      winner      <= winner_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    gnt_nxt       = gnt_q;
    dma_req_nxt   = dma_req_q;
    proto_err_nxt = proto_err_q;
    owner_nxt     = owner_q;
    rr_ptr_nxt    = rr_ptr;
    winner_nxt    = winner;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          winner_nxt  = pick_idx;
          dma_req_nxt = 1'b1;
          state_nxt   = HOLD_REQ;
        end
      end
      HOLD_REQ: begin
        // A vanished requester aborts even if the CPU acknowledges on the same edge.
        if (!bus.req[winner]) begin
          dma_req_nxt = 1'b0;
          state_nxt   = RELEASE;
        end else if (bus.dma_ack) begin
          gnt_nxt         = '0;
          gnt_nxt[winner] = 1'b1;
          owner_nxt       = winner;
          rr_ptr_nxt      = winner;
          state_nxt       = GRANT;
        end
      end
      GRANT: begin
        if (!bus.req[winner] || !bus.dma_ack || burst_done) begin
          gnt_nxt     = '0;
          dma_req_nxt = 1'b0;
          state_nxt   = RELEASE;
          if (!bus.dma_ack) proto_err_nxt = 1'b1;
        end
      end
      RELEASE: begin
        dma_req_nxt = 1'b0;
        if (!bus.dma_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    active_nxt = |gnt_nxt;
  end

  assign bus.gnt        = gnt_q;
  assign bus.dma_req    = dma_req_q;
  assign bus.dma_active = active_q;
  assign bus.proto_err  = proto_err_q;
  assign bus.owner_id   = owner_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter; timeout scenario runs when DMA_BUS_ARB_TIMEOUT_EN is defined.
module tb_dma_bus_arbiter;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic clk  = 1'b0;
  logic arst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [N_REQ-1:0] req_pat;

  always #5 clk = ~clk;

  dma_bus_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

`ifdef DMA_BUS_ARB_TIMEOUT_EN
  dma_bus_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .MAX_BURST(16)) dut (
`else
  dma_bus_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
`endif
    .clk  (clk),
    .arst (arst),
    .bus  (bus.master)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arst        = 1'b1;
    bus.req     = '0;
    bus.dma_ack = 1'b0;
    tick();
    tick();
    arst = 1'b0;
  endtask

  // One 3-cycle burst from IDLE with req_pat held; the winner drops req to end it.
  task automatic serve(input int exp_idx);
    logic [N_REQ-1:0] oh;
    oh = '0;
    oh[exp_idx] = 1'b1;
    tick();
    check_val("rr_dma_req_rise", 32'(bus.dma_req), 32'd1);
    check_val("rr_no_gnt_in_hold", 32'(bus.gnt), 32'd0);
    bus.dma_ack = 1'b1;
    tick();
    check_val("rr_gnt", 32'(bus.gnt), 32'(oh));
    check_val("rr_owner", 32'(bus.owner_id), 32'(exp_idx));
    tick();
    tick();
    check_val("rr_gnt_held", 32'(bus.gnt), 32'(oh));
    bus.req[exp_idx] = 1'b0;
    tick();
    check_val("rr_gnt_drop", 32'(bus.gnt), 32'd0);
    check_val("rr_dma_req_low", 32'(bus.dma_req), 32'd0);
    bus.dma_ack = 1'b0;
    bus.req     = req_pat;
    tick();
  endtask

  initial begin
    int n;
    bus.req     = '0;
    bus.dma_ack = 1'b0;
    req_pat     = '0;
    do_reset();
    check_val("rst_gnt", 32'(bus.gnt), 32'd0);
    check_val("rst_dma_req", 32'(bus.dma_req), 32'd0);
    check_val("rst_owner", 32'(bus.owner_id), 32'd0);
    check_val("rst_active", 32'(bus.dma_active), 32'd0);
    check_val("rst_proto_err", 32'(bus.proto_err), 32'd0);

    // Single request, CPU acks two clocks after dma_req.
    bus.req = 4'b0100;
    tick();
    check_val("single_dma_req", 32'(bus.dma_req), 32'd1);
    tick();
    check_val("single_wait_gnt", 32'(bus.gnt), 32'd0);
    bus.dma_ack = 1'b1;
    tick();
    check_val("single_gnt", 32'(bus.gnt), 32'b0100);
    check_val("single_owner", 32'(bus.owner_id), 32'd2);
    check_val("single_active", 32'(bus.dma_active), 32'd1);
    tick();
    bus.req = '0;
    tick();
    check_val("single_gnt_off", 32'(bus.gnt), 32'd0);
    check_val("single_dma_req_off", 32'(bus.dma_req), 32'd0);
    check_val("single_active_off", 32'(bus.dma_active), 32'd0);
    check_val("single_owner_kept", 32'(bus.owner_id), 32'd2);
    tick();
    bus.dma_ack = 1'b0;
    tick();
    tick();
    check_val("single_idle_quiet", 32'(bus.dma_req), 32'd0);

    // Round-robin with all requesters pending.
    do_reset();
    req_pat = 4'b1111;
    bus.req = req_pat;
    serve(0);
    serve(1);
    serve(2);
    serve(3);
    serve(0);
    bus.req = '0;
    req_pat = '0;

    // Abort before dma_ack leaves rr_ptr alone.
    do_reset();
    bus.req = 4'b0010;
    tick();
    check_val("abort_dma_req", 32'(bus.dma_req), 32'd1);
    bus.req = '0;
    tick();
    check_val("abort_dma_req_off", 32'(bus.dma_req), 32'd0);
    check_val("abort_no_gnt", 32'(bus.gnt), 32'd0);
    tick();
    bus.req = 4'b0011;
    tick();
    check_val("abort_rearb_req", 32'(bus.dma_req), 32'd1);
    bus.dma_ack = 1'b1;
    tick();
    check_val("abort_next_gnt", 32'(bus.gnt), 32'b0001);
    check_val("abort_next_owner", 32'(bus.owner_id), 32'd0);
    bus.req = '0;
    tick();
    bus.dma_ack = 1'b0;
    tick();

    // CPU drops dma_ack during a grant.
    do_reset();
    bus.req = 4'b0001;
    tick();
    bus.dma_ack = 1'b1;
    tick();
    check_val("perr_gnt", 32'(bus.gnt), 32'b0001);
    bus.dma_ack = 1'b0;
    tick();
    check_val("perr_gnt_off", 32'(bus.gnt), 32'd0);
    check_val("perr_flag", 32'(bus.proto_err), 32'd1);
    check_val("perr_dma_req_off", 32'(bus.dma_req), 32'd0);
    bus.req = '0;
    tick();
    tick();
    check_val("perr_sticky", 32'(bus.proto_err), 32'd1);

    // Reset pulse mid-burst.
    bus.req = 4'b0100;
    tick();
    bus.dma_ack = 1'b1;
    tick();
    check_val("mid_gnt", 32'(bus.gnt), 32'b0100);
    tick();
    arst    = 1'b1;
    bus.req = 4'b0101;
    tick();
    arst = 1'b0;
    check_val("mid_rst_gnt", 32'(bus.gnt), 32'd0);
    check_val("mid_rst_dma_req", 32'(bus.dma_req), 32'd0);
    check_val("mid_rst_proto_err", 32'(bus.proto_err), 32'd0);
    check_val("mid_rst_owner", 32'(bus.owner_id), 32'd0);
    tick();
    check_val("mid_rearb_req", 32'(bus.dma_req), 32'd1);
    tick();
    check_val("mid_rearb_gnt", 32'(bus.gnt), 32'b0001);
    bus.req = '0;
    tick();
    bus.dma_ack = 1'b0;
    tick();

`ifdef DMA_BUS_ARB_TIMEOUT_EN
    // Burst preemption at MAX_BURST=16 with two requesters held.
    do_reset();
    bus.req = 4'b0011;
    tick();
    bus.dma_ack = 1'b1;
    tick();
    n = 0;
    while (bus.gnt == 4'b0001 && n < 40) begin
      n++;
      tick();
    end
    check_val("to_len0", 32'(n), 32'd16);
    bus.dma_ack = 1'b0;
    tick();
    tick();
    bus.dma_ack = 1'b1;
    tick();
    check_val("to_gnt1", 32'(bus.gnt), 32'b0010);
    n = 0;
    while (bus.gnt == 4'b0010 && n < 40) begin
      n++;
      tick();
    end
    check_val("to_len1", 32'(n), 32'd16);
    bus.dma_ack = 1'b0;
    tick();
    tick();
    bus.dma_ack = 1'b1;
    tick();
    check_val("to_gnt0_again", 32'(bus.gnt), 32'b0001);
    bus.req = '0;
    tick();
    bus.dma_ack = 1'b0;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
